// File: rtl/vedic_mult_seq.sv
// Sequential WIDTH x WIDTH unsigned multiplier built around one 2x2 Vedic tile.
// Optional feature macro: VEDIC_SEQ_ZERO_BYPASS_EN (zero operands skip CALC).
module vedic_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic [1:0]           state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // ready/valid come from the state register only, valid holds until taken.

    localparam int N  = WIDTH / 2;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, next_state;

    logic [WIDTH-1:0]   a_reg, b_reg;
    logic [IW-1:0]      i_idx, j_idx;
    logic [2*WIDTH-1:0] acc, acc_next, term;
    logic [1:0]         da, db;
    logic [3:0]         tile;
    logic [IW:0]        digit_sum;
    logic               last_digit;
    logic               zero_op;

`ifdef VEDIC_SEQ_ZERO_BYPASS_EN
    assign zero_op = (a == '0) || (b == '0);
`else
    assign zero_op = 1'b0;
`endif

    // Digit selection and the 2x2 Vedic tile (vertical and crosswise).
    always_comb begin
        da        = 2'(a_reg >> {i_idx, 1'b0});
        db        = 2'(b_reg >> {j_idx, 1'b0});
        tile[0]   = da[0] & db[0];
        tile[1]   = (da[1] & db[0]) ^ (da[0] & db[1]);
        tile[2]   = (da[1] & db[1]) ^ ((da[1] & db[0]) & (da[0] & db[1]));
        tile[3]   = (da[1] & db[1]) & ((da[1] & db[0]) & (da[0] & db[1]));
        digit_sum = {1'b0, i_idx} + {1'b0, j_idx};
        term      = (2*WIDTH)'(tile) << {digit_sum, 1'b0};
        acc_next  = acc + term;
        last_digit = (i_idx == IW'(N - 1)) && (j_idx == IW'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE: begin
                next_state = IDLE;
                if (in_valid) next_state = zero_op ? DONE : CALC;
            end
            CALC: next_state = last_digit ? DONE : CALC;
            DONE: next_state = out_ready ? IDLE : DONE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state == CALC);
        out_valid = (state == DONE);
        state_dbg = state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            i_idx   <= '0;
            j_idx   <= '0;
            acc     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                        acc   <= '0;
                        i_idx <= '0;
                        j_idx <= '0;
                        if (zero_op) product <= '0;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    if (last_digit) begin
                        product <= acc_next;
                    end else if (j_idx == IW'(N - 1)) begin
                        j_idx <= '0;
                        i_idx <= i_idx + 1'b1;
                    end else begin
                        j_idx <= j_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vedic_mult_seq.sv
// Bench for vedic_mult_seq: directed scenarios plus a randomized run checked
// against a scoreboard of expected products and CALC cycle counts.
module tb_vedic_mult_seq;

    localparam int W  = 8;
    localparam int NN = (W / 2) * (W / 2);

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;
    logic           busy;
    logic [1:0]     state_dbg;

    vedic_mult_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .busy(busy), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [2*W-1:0] exp_q[$];
    int cyc_q[$];
    int calc_cnt = 0;
    int n_acc = 0, n_done = 0, n_flush = 0;
    logic prev_hold = 1'b0;
    logic [2*W-1:0] prev_prod = '0;
    bit stop = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_cycles(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef VEDIC_SEQ_ZERO_BYPASS_EN
        return (x == 0 || y == 0) ? 0 : NN;
`else
        return NN;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
        int guard = 0;
        a = x;
        b = y;
        in_valid = 1'b1;
        while (!in_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        check("out_timeout", 32'(out_valid), 1);
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Monitor: samples on the falling edge what the next rising edge will see.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                n_flush += exp_q.size();
                exp_q.delete();
                cyc_q.delete();
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("hold_valid", 32'(out_valid), 1);
                    check("hold_product", 32'(product), 32'(prev_prod));
                end
                if (busy) calc_cnt++;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_out", 1, 0);
                    end else begin
                        check("product", 32'(product), 32'(exp_q.pop_front()));
                        check("calc_cycles", calc_cnt, cyc_q.pop_front());
                    end
                    n_done++;
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back({{W{1'b0}}, a} * {{W{1'b0}}, b});
                    cyc_q.push_back(exp_cycles(a, b));
                    calc_cnt = 0;
                    n_acc++;
                end
                prev_hold = out_valid && !out_ready;
                prev_prod = product;
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_product", 32'(product), 0);
        check("rst_state", 32'(state_dbg), 0);

        // 0xFF * 0xFF: full-length CALC
        send(8'hFF, 8'hFF);
        for (int k = 0; k < NN; k++) begin
            check("t1_busy", 32'(busy), 1);
            check("t1_in_ready", 32'(in_ready), 0);
            check("t1_out_valid", 32'(out_valid), 0);
            tick();
        end
        check("t1_done_valid", 32'(out_valid), 1);
        check("t1_done_busy", 32'(busy), 0);
        check("t1_in_ready_done", 32'(in_ready), 0);
        check("t1_product", 32'(product), 32'h0000FE01);
        take();
        check("t1_in_ready_back", 32'(in_ready), 1);

        // zero operand latency
        send(8'h00, 8'h5A);
        wait_out(n);
`ifdef VEDIC_SEQ_ZERO_BYPASS_EN
        check("t2_latency", n, 0);
`else
        check("t2_latency", n, NN);
`endif
        check("t2_product", 32'(product), 0);
        take();

        // back-pressure: product held while out_ready is low
        send(8'h3C, 8'hA7);
        wait_out(n);
        for (int k = 0; k < 5; k++) begin
            check("t3_hold_valid", 32'(out_valid), 1);
            check("t3_hold_product", 32'(product), 32'h00002724);
            tick();
        end
        take();
        check("t3_in_ready", 32'(in_ready), 1);

        // in_valid during CALC/DONE ignored; operand changes after acceptance ignored
        send(8'h12, 8'h34);
        a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
        wait_out(n);
        check("t4_product", 32'(product), 32'h000003A8);
        check("t4_in_ready", 32'(in_ready), 0);
        take();
        check("t4_in_ready_back", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        check("t4_second_busy", 32'(busy), 1);
        wait_out(n);
        check("t4_second_product", 32'(product), 32'h0000FE01);
        take();

        // reset mid-operation aborts
        send(8'hAB, 8'hCD);
        repeat (6) tick();
        check("t5_busy_before_rst", 32'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_state", 32'(state_dbg), 0);
        check("t5_product", 32'(product), 0);
        check("t5_out_valid", 32'(out_valid), 0);
        check("t5_in_ready", 32'(in_ready), 1);
        check("t5_busy", 32'(busy), 0);
        send(8'h02, 8'h03);
        wait_out(n);
        check("t5_new_product", 32'(product), 32'h00000006);
        take();

        // randomized traffic with random gaps and back-pressure
        fork
            begin
                int guard = 0;
                for (int k = 0; k < 1000; k++) begin
                    logic [W-1:0] x, y;
                    repeat ($urandom_range(0, 3)) tick();
                    x = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom_range(0, 255));
                    y = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom_range(0, 255));
                    send(x, y);
                end
                while ((exp_q.size() != 0 || out_valid) && guard < 500) begin
                    tick();
                    guard++;
                end
                check("drain", 32'(exp_q.size()), 0);
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    out_ready = 1'($urandom_range(0, 1));
                    tick();
                end
                out_ready = 1'b0;
            end
        join

        repeat (2) tick();
        check("handshakes", n_done, n_acc - n_flush);
        check("flushed", n_flush, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
